// File: rtl/shift_rr_arbiter_pkg.sv
// Shared definitions for the shift round-robin arbiter slice.
//   SHIFT_DATA_W / SHIFT_AMT_W : operand and shift-amount widths of the shared shifter
//   MAX_REQ                    : largest supported requester count
//   slot_state_t               : result slot occupancy
//   clog2 / id_width           : elaboration-time width helpers
package shift_rr_arbiter_pkg;

  localparam int unsigned SHIFT_DATA_W = 8;
  localparam int unsigned SHIFT_AMT_W  = 3;
  localparam int unsigned MAX_REQ      = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned p = 1; p < value; p = p << 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Requester-id width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req <= 1) ? 1 : clog2(num_req);
  endfunction

endpackage

// File: rtl/shift_rr_arbiter_shifter.sv
// 8-bit logical right barrel shifter, three log stages, zero fill.
//   in   : operand
//   ctrl : shift amount 0..7
//   out  : in >> ctrl
module shift_rr_arbiter_shifter
  import shift_rr_arbiter_pkg::*;
(
  input  logic [SHIFT_DATA_W-1:0] in,
  input  logic [SHIFT_AMT_W-1:0]  ctrl,
  output logic [SHIFT_DATA_W-1:0] out
);

  logic [SHIFT_DATA_W-1:0] stage0;
  logic [SHIFT_DATA_W-1:0] stage1;

  assign stage0 = ctrl[0] ? {1'b0, in[SHIFT_DATA_W-1:1]}     : in;
  assign stage1 = ctrl[1] ? {2'b0, stage0[SHIFT_DATA_W-1:2]} : stage0;
  assign out    = ctrl[2] ? {4'b0, stage1[SHIFT_DATA_W-1:4]} : stage1;

endmodule

// File: rtl/shift_rr_arbiter.sv
// Round-robin arbiter sharing one 8-bit logical right shifter among NUM_REQ clients.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (req_ready one-hot or zero, combinational)
//   req_data, req_amt     : packed per-requester operand and shift amount
//   res_valid/res_ready   : result slot handshake
//   res_data, res_id      : shifted byte and the id of the requester that produced it
module shift_rr_arbiter
  import shift_rr_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [SHIFT_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [SHIFT_AMT_W*NUM_REQ-1:0]  req_amt,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            res_valid,
  output logic [SHIFT_DATA_W-1:0]         res_data,
  output logic [ID_W-1:0]                 res_id,
  input  logic                            res_ready
);

  localparam int unsigned SUM_W = ID_W + 1;

  slot_state_t             state_q;
  slot_state_t             state_d;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         grant_id;
  logic                    found;
  logic                    can_accept;
  logic                    accept;
  logic [NUM_REQ-1:0]      rot_valid;
  logic [SUM_W-1:0]        sum;
  logic [SHIFT_DATA_W-1:0] data_sel;
  logic [SHIFT_AMT_W-1:0]  amt_sel;
  logic [SHIFT_DATA_W-1:0] shifted;

  // Priority pick: rotate a doubled request vector so rr_ptr lands at bit 0,
  // take the first set bit, then map the offset back to a requester index.
  always_comb begin
    rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    found     = 1'b0;
    grant_id  = '0;
    sum       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot_valid[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + SUM_W'(k);
        if (sum >= SUM_W'(NUM_REQ)) begin
          sum = sum - SUM_W'(NUM_REQ);
        end
        grant_id = sum[ID_W-1:0];
      end
    end
  end

  // The slot can take a new result when empty or being drained this cycle.
  assign can_accept = (state_q == SLOT_EMPTY) | res_ready;
  assign accept     = found & can_accept & ~rst;

  // Grant decode and winner operand mux.
  always_comb begin
    req_ready = '0;
    data_sel  = '0;
    amt_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        req_ready[i] = accept;
        data_sel     = req_data[i*SHIFT_DATA_W +: SHIFT_DATA_W];
        amt_sel      = req_amt[i*SHIFT_AMT_W +: SHIFT_AMT_W];
      end
    end
  end

  shift_rr_arbiter_shifter u_shifter (
    .in   (data_sel),
    .ctrl (amt_sel),
    .out  (shifted)
  );

  // Slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Slot next-state: accept always fills; a consume without accept empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (accept) begin
          state_d = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (accept) begin
          state_d = SLOT_FULL;
        end else if (res_ready) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  assign res_valid = (state_q == SLOT_FULL);

  // Result payload and round-robin pointer; both held when nothing is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data <= '0;
      res_id   <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      res_data <= shifted;
      res_id   <= grant_id;
      rr_ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_rr_arbiter.sv
// Directed self-checking bench for shift_rr_arbiter (NUM_REQ = 4).
module tb_shift_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [11:0] req_amt;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [1:0]  res_id;
  logic        res_ready;

  int n_assert;
  int n_fail;

  shift_rr_arbiter #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] d, input logic [2:0] a);
    req_data[i*8 +: 8] = d;
    req_amt[i*3 +: 3]  = a;
  endtask

  task automatic chk_res(input string tag, input logic v, input logic [7:0] d, input logic [1:0] id);
    chk({tag, ".valid"}, 32'(res_valid), 32'(v));
    chk({tag, ".data"},  32'(res_data),  32'(d));
    chk({tag, ".id"},    32'(res_id),    32'(id));
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'h1234_5678;
    req_amt   = 12'h5A5;
    res_ready = 1'b1;

    // 1: reset held two cycles with every request valid
    #1;
    chk("rst.ready0", 32'(req_ready), 32'h0);
    tick();
    chk("rst.ready1", 32'(req_ready), 32'h0);
    chk_res("rst.c1", 1'b0, 8'h00, 2'd0);
    tick();
    chk("rst.ready2", 32'(req_ready), 32'h0);
    chk_res("rst.c2", 1'b0, 8'h00, 2'd0);

    // 2: single request, B6 >> 3 = 16
    rst       = 1'b0;
    req_valid = 4'b0001;
    set_op(0, 8'hB6, 3'd3);
    #1;
    chk("single.ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    chk_res("single.res", 1'b1, 8'h16, 2'd0);

    // Return rr_ptr to 0 before the rotation test
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_res("rst2", 1'b0, 8'h00, 2'd0);

    // 3: all four valid, FF with amounts 0/1/2/7
    req_valid = 4'hF;
    set_op(0, 8'hFF, 3'd0);
    set_op(1, 8'hFF, 3'd1);
    set_op(2, 8'hFF, 3'd2);
    set_op(3, 8'hFF, 3'd7);
    #1;
    chk("rr.ready0", 32'(req_ready), 32'b0001);
    tick();
    chk_res("rr.r0", 1'b1, 8'hFF, 2'd0);
    req_valid = 4'b1110;
    #1;
    chk("rr.ready1", 32'(req_ready), 32'b0010);
    tick();
    chk_res("rr.r1", 1'b1, 8'h7F, 2'd1);
    req_valid = 4'b1100;
    #1;
    chk("rr.ready2", 32'(req_ready), 32'b0100);
    tick();
    chk_res("rr.r2", 1'b1, 8'h3F, 2'd2);
    req_valid = 4'b1000;
    #1;
    chk("rr.ready3", 32'(req_ready), 32'b1000);
    tick();
    chk_res("rr.r3", 1'b1, 8'h01, 2'd3);
    req_valid = 4'b0000;
    tick();
    chk("rr.drain", 32'(res_valid), 32'h0);

    // 4: stall with slot full and req1 waiting; rr_ptr is 0 here
    res_ready = 1'b0;
    req_valid = 4'b0001;
    set_op(0, 8'h5A, 3'd1);
    #1;
    chk("stall.fill.ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0010;
    set_op(1, 8'hC3, 3'd4);
    for (int c = 0; c < 5; c++) begin
      chk("stall.ready", 32'(req_ready), 32'h0);
      chk_res("stall.hold", 1'b1, 8'h2D, 2'd0);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("stall.release.ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    chk_res("stall.next", 1'b1, 8'h0C, 2'd1);

    // 5: rr_ptr is 2; req2 with amt 0 moves it to 3, then req3 and req1 compete
    req_valid = 4'b0100;
    set_op(2, 8'hA5, 3'd0);
    #1;
    chk("wrap.pre.ready", 32'(req_ready), 32'b0100);
    tick();
    chk_res("wrap.pass", 1'b1, 8'hA5, 2'd2);
    req_valid = 4'b1010;
    set_op(3, 8'hF0, 3'd7);
    set_op(1, 8'h7E, 3'd1);
    #1;
    chk("wrap.ready3", 32'(req_ready), 32'b1000);
    tick();
    chk_res("wrap.g3", 1'b1, 8'h01, 2'd3);
    req_valid = 4'b0010;
    #1;
    chk("wrap.ready1", 32'(req_ready), 32'b0010);
    tick();
    chk_res("wrap.g1", 1'b1, 8'h3F, 2'd1);
    req_valid = 4'b0000;

    // 6: rr_ptr is 2; fill via req1 (pointer stays 2), stall, then reset
    req_valid = 4'b0010;
    set_op(1, 8'h3C, 3'd2);
    #1;
    chk("rmid.fill.ready", 32'(req_ready), 32'b0010);
    tick();
    chk_res("rmid.full", 1'b1, 8'h0F, 2'd1);
    res_ready = 1'b0;
    req_valid = 4'b0101;
    set_op(0, 8'h81, 3'd7);
    set_op(2, 8'h44, 3'd2);
    #1;
    chk("rmid.stall.ready", 32'(req_ready), 32'h0);
    rst       = 1'b1;
    res_ready = 1'b1;
    #1;
    chk("rmid.rst.ready", 32'(req_ready), 32'h0);
    tick();
    chk_res("rmid.cleared", 1'b0, 8'h00, 2'd0);
    rst = 1'b0;
    #1;
    chk("rmid.after.ready", 32'(req_ready), 32'b0001);
    tick();
    chk_res("rmid.after", 1'b1, 8'h01, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
